// File: rtl/regfile_writeback_if.sv
// Writeback bundle: ALU and load result channels in, regfile write port and
// hazard-visibility outputs out. The DUT sits on the slave side.
interface regfile_writeback_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int NREG  = 1 << ADDR_W;

   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              rf_grant;
   logic              rf_w_en;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_din;
   logic [NREG-1:0]   pend_mask;
   logic [CNT_W-1:0]  q_count;

   modport master (
      output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, rf_grant,
      input  alu_ready, ld_ready, rf_w_en, rf_addr, rf_din, pend_mask, q_count
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, rf_grant,
      output alu_ready, ld_ready, rf_w_en, rf_addr, rf_din, pend_mask, q_count
   );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback queue: merges ALU and load results into one
// in-order FIFO and drains it through the single regfile write port.
module regfile_writeback #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   regfile_writeback_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_ent_t;

   wb_ent_t          mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, ld_slot;
   logic [CNT_W-1:0] count, free;
   logic             rr_ld;       // 1: load source wins the next contested slot
   logic             push_alu, push_ld, pop, contested;
   logic             alu_rdy, ld_rdy;
   logic [NREG-1:0]  pend;
   wb_ent_t          head;

   // free space comes from registered count only; a same-cycle pop never frees a slot
   assign free = CNT_W'(DEPTH) - count;

   // acceptance: both take a slot when two are free, otherwise round-robin for the last one
   always_comb begin
      alu_rdy   = 1'b0;
      ld_rdy    = 1'b0;
      contested = 1'b0;
      if (free >= CNT_W'(2)) begin
         alu_rdy = 1'b1;
         ld_rdy  = 1'b1;
      end else if (free == CNT_W'(1)) begin
         alu_rdy   = !bus.ld_valid  || !rr_ld;
         ld_rdy    = !bus.alu_valid ||  rr_ld;
         contested = bus.alu_valid && bus.ld_valid;
      end
   end

   assign bus.alu_ready = alu_rdy;
   assign bus.ld_ready  = ld_rdy;
   assign push_alu      = bus.alu_valid && alu_rdy;
   assign push_ld       = bus.ld_valid  && ld_rdy;
   // ALU entry goes first when both land in the same cycle
   assign ld_slot       = wr_ptr + PTR_W'(push_alu);

   assign pop          = (count != '0) && bus.rf_grant;
   assign head         = mem[rd_ptr];
   assign bus.rf_w_en  = pop;
   assign bus.rf_addr  = head.addr;
   assign bus.rf_din   = head.data;
   assign bus.q_count  = count;

   // queue bookkeeping and arbitration priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rr_ld  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_alu) + PTR_W'(push_ld);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_alu) + CNT_W'(push_ld) - CNT_W'(pop);
         if (contested)
            rr_ld <= !rr_ld;
      end
   end

   // entry storage; contents survive reset, validity is carried by count
   always_ff @(posedge clk) begin
      if (push_alu)
         mem[wr_ptr] <= '{addr: bus.alu_addr, data: bus.alu_data};
      if (push_ld)
         mem[ld_slot] <= '{addr: bus.ld_addr, data: bus.ld_data};
   end

   // pending-write mask: OR of one-hot destinations over the occupied slots
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count)
            pend[mem[rd_ptr + PTR_W'(i)].addr] = 1'b1;
      end
   end

   assign bus.pend_mask = pend;
endmodule
